noc_network_interface: RTL and testbench

- Endpoint adapter between a processing core and the local port of a mesh router.
- Injection path: packs core requests into 32-bit flits, queues them, and drives the router's local input while honouring the router's local full flag.
- Ejection path: receives flits from the router's local output, checks the destination, buffers them, and hands them to the core over a valid/ready handshake.
- Keeps traffic and error counters for debug.

---
 rtl/noc_network_interface.sv | 151 +++++++++++++++
 tb/tb_noc_network_interface.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_network_interface.sv
// Network interface between a core and a mesh router local port: packs core messages into
// 32-bit flits for injection, filters and buffers ejected flits for the core, and keeps debug counters.
`timescale 1ns/1ps
module noc_network_interface #(
  parameter logic [2:0] NODE_ADDRESS = 3'b000,
  parameter int         TXQ_DEPTH    = 4,
  parameter int         RXQ_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_tx_valid,
  output logic        core_tx_ready,
  input  logic [2:0]  core_tx_dst,
  input  logic [17:0] core_tx_payload,
  output logic        core_rx_valid,
  input  logic        core_rx_ready,
  output logic [2:0]  core_rx_src,
  output logic [7:0]  core_rx_seq,
  output logic [17:0] core_rx_payload,
  output logic [31:0] NOC_DATA_OUT,
  output logic        NOC_DATA_VALID_OUT,
  input  logic        NOC_FULL_IN,
  input  logic [31:0] NOC_DATA_IN,
  input  logic        NOC_DATA_VALID_IN,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count,
  output logic [7:0]  drop_count,
  output logic [7:0]  misroute_count
);
  // Handshakes: a core transfer happens on the edge where valid & ready are both high; valid
  // and its payload stay stable until then. The router side has no ready: NOC_FULL_IN gates
  // injection, and ejected flits must be taken or counted as dropped in the cycle they arrive.

  localparam int TAW = $clog2(TXQ_DEPTH);
  localparam int RAW = $clog2(RXQ_DEPTH);
  localparam logic [TAW:0] TX_PTR_ONE = {{TAW{1'b0}}, 1'b1};
  localparam logic [RAW:0] RX_PTR_ONE = {{RAW{1'b0}}, 1'b1};

  // Injection queue: pointers carry one extra wrap bit to separate full from empty.
  logic [31:0]  r_txq_mem [TXQ_DEPTH];
  logic [TAW:0] r_tx_wr_ptr;
  logic [TAW:0] r_tx_rd_ptr;
  logic [7:0]   r_seq;
  logic [31:0]  r_noc_data;
  logic         r_noc_valid;
  logic [15:0]  r_tx_count;

  logic         w_tx_empty;
  logic         w_tx_full;
  logic         w_tx_push;
  logic         w_tx_pop;
  logic [31:0]  w_tx_flit;
  logic [31:0]  w_tx_head;

  assign w_tx_empty = (r_tx_wr_ptr == r_tx_rd_ptr);
  assign w_tx_full  = (r_tx_wr_ptr[TAW] != r_tx_rd_ptr[TAW]) &&
                      (r_tx_wr_ptr[TAW-1:0] == r_tx_rd_ptr[TAW-1:0]);
  assign w_tx_push  = core_tx_valid & ~w_tx_full;
  assign w_tx_pop   = ~w_tx_empty & ~NOC_FULL_IN;
  assign w_tx_flit  = {core_tx_payload, r_seq, NODE_ADDRESS, core_tx_dst};
  assign w_tx_head  = r_txq_mem[r_tx_rd_ptr[TAW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_seq       <= '0;
      r_noc_data  <= '0;
      r_noc_valid <= 1'b0;
      r_tx_count  <= '0;
    end else begin
      r_noc_valid <= w_tx_pop;
      if (w_tx_push) begin
        r_tx_wr_ptr <= r_tx_wr_ptr + TX_PTR_ONE;
        r_seq       <= r_seq + 8'd1;
      end
      if (w_tx_pop) begin
        r_tx_rd_ptr <= r_tx_rd_ptr + TX_PTR_ONE;
        r_noc_data  <= w_tx_head;
        r_tx_count  <= r_tx_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_txq_mem[r_tx_wr_ptr[TAW-1:0]] <= w_tx_flit;
  end

  // Ejection queue: a pop in the same cycle frees the slot, so a full queue still accepts.
  logic [31:0]  r_rxq_mem [RXQ_DEPTH];
  logic [RAW:0] r_rx_wr_ptr;
  logic [RAW:0] r_rx_rd_ptr;
  logic [15:0]  r_rx_count;
  logic [7:0]   r_drop_count;
  logic [7:0]   r_misroute_count;

  logic         w_rx_empty;
  logic         w_rx_full;
  logic         w_dst_ok;
  logic         w_rx_pop;
  logic         w_rx_push;
  logic         w_rx_drop;
  logic         w_rx_misroute;
  logic [31:0]  w_rx_head;

  assign w_rx_empty    = (r_rx_wr_ptr == r_rx_rd_ptr);
  assign w_rx_full     = (r_rx_wr_ptr[RAW] != r_rx_rd_ptr[RAW]) &&
                         (r_rx_wr_ptr[RAW-1:0] == r_rx_rd_ptr[RAW-1:0]);
  assign w_dst_ok      = (NOC_DATA_IN[2:0] == NODE_ADDRESS);
  assign w_rx_pop      = ~w_rx_empty & core_rx_ready;
  assign w_rx_misroute = NOC_DATA_VALID_IN & ~w_dst_ok;
  assign w_rx_drop     = NOC_DATA_VALID_IN & w_dst_ok & w_rx_full & ~w_rx_pop;
  assign w_rx_push     = NOC_DATA_VALID_IN & w_dst_ok & (~w_rx_full | w_rx_pop);
  assign w_rx_head     = r_rxq_mem[r_rx_rd_ptr[RAW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_wr_ptr      <= '0;
      r_rx_rd_ptr      <= '0;
      r_rx_count       <= '0;
      r_drop_count     <= '0;
      r_misroute_count <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_wr_ptr <= r_rx_wr_ptr + RX_PTR_ONE;
        r_rx_count  <= r_rx_count + 16'd1;
      end
      if (w_rx_pop) r_rx_rd_ptr <= r_rx_rd_ptr + RX_PTR_ONE;
      if (w_rx_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
      if (w_rx_misroute && (r_misroute_count != 8'hFF))
        r_misroute_count <= r_misroute_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rxq_mem[r_rx_wr_ptr[RAW-1:0]] <= NOC_DATA_IN;
  end

  assign core_tx_ready      = ~w_tx_full;
  assign NOC_DATA_OUT       = r_noc_data;
  assign NOC_DATA_VALID_OUT = r_noc_valid;
  assign core_rx_valid      = ~w_rx_empty;
  assign core_rx_src        = w_rx_head[5:3];
  assign core_rx_seq        = w_rx_head[13:6];
  assign core_rx_payload    = w_rx_head[31:14];
  assign tx_count           = r_tx_count;
  assign rx_count           = r_rx_count;
  assign drop_count         = r_drop_count;
  assign misroute_count     = r_misroute_count;

endmodule

// File: tb/tb_noc_network_interface.sv
// Bench for noc_network_interface: directed scenarios plus random traffic, all checked against a
// queue-based transaction model of the interface kept here.
`timescale 1ns/1ps
module tb_noc_network_interface;
  localparam logic [2:0] NODE  = 3'd2;
  localparam int         DEPTH = 4;

  // Clock / reset block
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        core_tx_valid;
  logic        core_tx_ready;
  logic [2:0]  core_tx_dst;
  logic [17:0] core_tx_payload;
  logic        core_rx_valid;
  logic        core_rx_ready;
  logic [2:0]  core_rx_src;
  logic [7:0]  core_rx_seq;
  logic [17:0] core_rx_payload;
  logic [31:0] noc_data_out;
  logic        noc_data_valid_out;
  logic        noc_full_in;
  logic [31:0] noc_data_in;
  logic        noc_data_valid_in;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic [7:0]  drop_count;
  logic [7:0]  misroute_count;

  noc_network_interface #(.NODE_ADDRESS(NODE), .TXQ_DEPTH(DEPTH), .RXQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
    .core_tx_dst(core_tx_dst), .core_tx_payload(core_tx_payload),
    .core_rx_valid(core_rx_valid), .core_rx_ready(core_rx_ready),
    .core_rx_src(core_rx_src), .core_rx_seq(core_rx_seq), .core_rx_payload(core_rx_payload),
    .NOC_DATA_OUT(noc_data_out), .NOC_DATA_VALID_OUT(noc_data_valid_out),
    .NOC_FULL_IN(noc_full_in), .NOC_DATA_IN(noc_data_in), .NOC_DATA_VALID_IN(noc_data_valid_in),
    .tx_count(tx_count), .rx_count(rx_count),
    .drop_count(drop_count), .misroute_count(misroute_count)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard / reference model: message queues plus expected output and counters
  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];
  logic [7:0]  m_seq;
  logic        m_out_valid;
  logic [31:0] m_out_data;
  logic [15:0] m_tx_count;
  logic [15:0] m_rx_count;
  logic [7:0]  m_drop;
  logic [7:0]  m_mis;

  // Advance the model by one clock edge using the current inputs, then step the DUT.
  task automatic tick();
    bit tx_push, tx_pop, rx_pop, rx_room;
    if (!rst_n) begin
      exp_q.delete();
      rx_q.delete();
      m_seq = 0; m_out_valid = 0; m_out_data = 0;
      m_tx_count = 0; m_rx_count = 0; m_drop = 0; m_mis = 0;
    end else begin
      tx_push = core_tx_valid && (exp_q.size() < DEPTH);
      tx_pop  = (exp_q.size() > 0) && !noc_full_in;
      rx_pop  = (rx_q.size() > 0) && core_rx_ready;
      rx_room = (rx_q.size() < DEPTH) || rx_pop;
      if (tx_pop) begin
        m_out_data  = exp_q.pop_front();
        m_out_valid = 1;
        m_tx_count  = m_tx_count + 1;
      end else begin
        m_out_valid = 0;
      end
      if (tx_push) begin
        exp_q.push_back({core_tx_payload, m_seq, NODE, core_tx_dst});
        m_seq = m_seq + 1;
      end
      if (rx_pop) void'(rx_q.pop_front());
      if (noc_data_valid_in) begin
        if (noc_data_in[2:0] != NODE) begin
          if (m_mis != 8'hFF) m_mis = m_mis + 1;
        end else if (!rx_room) begin
          if (m_drop != 8'hFF) m_drop = m_drop + 1;
        end else begin
          rx_q.push_back(noc_data_in);
          m_rx_count = m_rx_count + 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_idle();
    core_tx_valid = 0; core_tx_dst = 0; core_tx_payload = 0;
    core_rx_ready = 0; noc_full_in = 0; noc_data_in = 0; noc_data_valid_in = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  function automatic logic [31:0] rand_flit(input logic [2:0] dst);
    logic [17:0] p;
    logic [7:0]  s;
    logic [2:0]  src;
    p = 18'($urandom); s = 8'($urandom); src = 3'($urandom);
    return {p, s, src, dst};
  endfunction

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (core_tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %0b want 1", core_tx_ready); end
    checks++; if (noc_data_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %0b want 0", noc_data_valid_out); end
    checks++; if (noc_data_out !== 32'd0) begin errors++; $display("FAIL reset_data_out: got %0h want 0", noc_data_out); end
    checks++; if (core_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %0b want 0", core_rx_valid); end
    checks++; if ({tx_count, rx_count, drop_count, misroute_count} !== 48'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0h/%0h/%0h/%0h want 0", tx_count, rx_count, drop_count, misroute_count);
    end
  endtask

  task automatic test_inject_basic();
    logic [31:0] want;
    logic [17:0] p;
    logic [2:0]  d;
    do_reset();
    core_tx_dst = 3'd5; core_tx_payload = 18'h2A5A; core_tx_valid = 1;
    tick();
    core_tx_valid = 0;
    checks++; if (noc_data_valid_out !== 1'b0) begin errors++; $display("FAIL inject_early_valid: got %0b want 0", noc_data_valid_out); end
    tick();
    want = {18'h2A5A, 8'd0, 3'd2, 3'd5};
    checks++; if (noc_data_valid_out !== 1'b1) begin errors++; $display("FAIL inject_valid: got %0b want 1", noc_data_valid_out); end
    checks++; if (noc_data_out !== want) begin errors++; $display("FAIL inject_flit: got %0h want %0h", noc_data_out, want); end
    checks++; if (tx_count !== 16'd1) begin errors++; $display("FAIL inject_tx_count: got %0d want 1", tx_count); end
    tick();
    checks++; if (noc_data_valid_out !== 1'b0 || noc_data_out !== want) begin
      errors++;
      $display("FAIL inject_hold: got valid=%0b data=%0h want 0/%0h", noc_data_valid_out, noc_data_out, want);
    end
    p = 18'($urandom); d = 3'($urandom);
    core_tx_dst = d; core_tx_payload = p; core_tx_valid = 1;
    tick();
    core_tx_valid = 0;
    tick();
    want = {p, 8'd1, NODE, d};
    checks++; if (noc_data_out !== want || noc_data_valid_out !== 1'b1) begin
      errors++;
      $display("FAIL inject_second_seq: got %0h want %0h", noc_data_out, want);
    end
  endtask

  task automatic test_inject_backpressure();
    do_reset();
    noc_full_in = 1;
    for (int i = 0; i < 6; i++) begin
      core_tx_dst = 3'($urandom); core_tx_payload = 18'($urandom); core_tx_valid = 1;
      tick();
      checks++; if (noc_data_valid_out !== 1'b0) begin errors++; $display("FAIL bp_no_valid: i=%0d got %0b want 0", i, noc_data_valid_out); end
      checks++; if (core_tx_ready !== (i < 3)) begin errors++; $display("FAIL bp_ready: i=%0d got %0b want %0b", i, core_tx_ready, i < 3); end
    end
    core_tx_valid = 0;
    noc_full_in = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (noc_data_valid_out !== 1'b1 || noc_data_out[13:6] !== 8'(i)) begin
        errors++;
        $display("FAIL bp_drain: i=%0d got valid=%0b seq=%0d want 1/%0d", i, noc_data_valid_out, noc_data_out[13:6], i);
      end
      checks++; if (noc_data_out !== m_out_data) begin errors++; $display("FAIL bp_drain_flit: got %0h want %0h", noc_data_out, m_out_data); end
    end
    tick();
    checks++; if (noc_data_valid_out !== 1'b0 || core_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_after: got valid=%0b ready=%0b want 0/1", noc_data_valid_out, core_tx_ready);
    end
  endtask

  task automatic test_eject_drop();
    logic [31:0] sent[$];
    logic [31:0] f;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      f = rand_flit(NODE);
      if (i < 4) sent.push_back(f);
      noc_data_in = f; noc_data_valid_in = 1;
      tick();
    end
    noc_data_valid_in = 0;
    checks++; if (rx_count !== 16'd4) begin errors++; $display("FAIL eject_rx_count: got %0d want 4", rx_count); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL eject_drop_count: got %0d want 2", drop_count); end
    for (int k = 0; k < 3; k++) begin
      f = sent[0];
      checks++; if (core_rx_valid !== 1'b1 || {core_rx_payload, core_rx_seq, core_rx_src} !== {f[31:14], f[13:6], f[5:3]}) begin
        errors++;
        $display("FAIL eject_stall: got v=%0b %0h/%0h/%0h want %0h/%0h/%0h", core_rx_valid,
                 core_rx_payload, core_rx_seq, core_rx_src, f[31:14], f[13:6], f[5:3]);
      end
      tick();
    end
    core_rx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      f = sent[i];
      checks++; if (core_rx_valid !== 1'b1 || {core_rx_payload, core_rx_seq, core_rx_src} !== {f[31:14], f[13:6], f[5:3]}) begin
        errors++;
        $display("FAIL eject_order: i=%0d got v=%0b %0h/%0h/%0h want %0h/%0h/%0h", i, core_rx_valid,
                 core_rx_payload, core_rx_seq, core_rx_src, f[31:14], f[13:6], f[5:3]);
      end
      tick();
    end
    checks++; if (core_rx_valid !== 1'b0) begin errors++; $display("FAIL eject_empty: got %0b want 0", core_rx_valid); end
    core_rx_ready = 0;
  endtask

  task automatic test_misroute();
    logic [2:0] d;
    do_reset();
    noc_data_in = rand_flit(3'd3); noc_data_valid_in = 1;
    tick();
    noc_data_valid_in = 0;
    checks++; if (misroute_count !== 8'd1) begin errors++; $display("FAIL misroute_one: got %0d want 1", misroute_count); end
    checks++; if (core_rx_valid !== 1'b0 || rx_count !== 16'd0) begin
      errors++;
      $display("FAIL misroute_no_rx: got v=%0b rx=%0d want 0/0", core_rx_valid, rx_count);
    end
    noc_data_valid_in = 1;
    for (int i = 0; i < 300; i++) begin
      d = 3'($urandom_range(0, 6));
      if (d >= NODE) d = d + 3'd1;
      noc_data_in = rand_flit(d);
      tick();
    end
    noc_data_valid_in = 0;
    checks++; if (misroute_count !== 8'd255) begin errors++; $display("FAIL misroute_sat: got %0d want 255", misroute_count); end
    checks++; if (core_rx_valid !== 1'b0 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL misroute_side: got v=%0b drop=%0d want 0/0", core_rx_valid, drop_count);
    end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] want[$];
    logic [31:0] f;
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      f = rand_flit(NODE);
      if (i > 0) want.push_back(f);
      noc_data_in = f; noc_data_valid_in = 1;
      tick();
    end
    f = rand_flit(NODE);
    want.push_back(f);
    noc_data_in = f; noc_data_valid_in = 1; core_rx_ready = 1;
    tick();
    noc_data_valid_in = 0;
    checks++; if (drop_count !== 8'd0 || rx_count !== 16'd5) begin
      errors++;
      $display("FAIL fullpp_counts: got drop=%0d rx=%0d want 0/5", drop_count, rx_count);
    end
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (core_rx_valid) begin
        if (n < 4) begin
          f = want[n];
          checks++; if ({core_rx_payload, core_rx_seq, core_rx_src} !== {f[31:14], f[13:6], f[5:3]}) begin
            errors++;
            $display("FAIL fullpp_order: n=%0d got %0h/%0h/%0h want %0h/%0h/%0h", n,
                     core_rx_payload, core_rx_seq, core_rx_src, f[31:14], f[13:6], f[5:3]);
          end
        end
        n++;
      end
      tick();
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL fullpp_occupancy: got %0d want 4", n); end
    core_rx_ready = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    core_tx_valid = 1; core_tx_payload = 18'($urandom);
    tick();
    core_tx_valid = 0;
    tick();
    noc_full_in = 1;
    for (int i = 0; i < 2; i++) begin
      core_tx_valid = 1; core_tx_dst = 3'($urandom); core_tx_payload = 18'($urandom);
      noc_data_in = rand_flit(NODE); noc_data_valid_in = 1;
      tick();
    end
    core_tx_valid = 0;
    noc_data_in = rand_flit(3'd7);
    tick();
    noc_data_valid_in = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++; if (noc_data_valid_out !== 1'b0 || core_rx_valid !== 1'b0 || core_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_valids: got vo=%0b rv=%0b tr=%0b want 0/0/1", noc_data_valid_out, core_rx_valid, core_tx_ready);
    end
    checks++; if ({tx_count, rx_count, drop_count, misroute_count} !== 48'd0 || noc_data_out !== 32'd0) begin
      errors++;
      $display("FAIL midreset_counters: got %0h/%0h/%0h/%0h data=%0h want 0", tx_count, rx_count,
               drop_count, misroute_count, noc_data_out);
    end
    noc_full_in = 0;
    core_tx_valid = 1; core_tx_payload = 18'($urandom);
    tick();
    core_tx_valid = 0;
    tick();
    checks++; if (noc_data_valid_out !== 1'b1 || noc_data_out[13:6] !== 8'd0) begin
      errors++;
      $display("FAIL midreset_seq: got v=%0b seq=%0d want 1/0", noc_data_valid_out, noc_data_out[13:6]);
    end
  endtask

  task automatic test_random();
    logic [31:0] h;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      core_tx_valid     = 1'($urandom);
      core_tx_dst       = 3'($urandom);
      core_tx_payload   = 18'($urandom);
      noc_full_in       = ($urandom_range(0, 3) == 0);
      noc_data_valid_in = ($urandom_range(0, 2) != 0);
      noc_data_in       = rand_flit(($urandom_range(0, 4) == 0) ? 3'($urandom) : NODE);
      core_rx_ready     = ($urandom_range(0, 2) == 0);
      tick();
      checks++; if (core_tx_ready !== (exp_q.size() < DEPTH)) begin
        errors++;
        $display("FAIL rand_tx_ready: c=%0d got %0b want %0b", c, core_tx_ready, exp_q.size() < DEPTH);
      end
      checks++; if (noc_data_valid_out !== m_out_valid || noc_data_out !== m_out_data) begin
        errors++;
        $display("FAIL rand_noc_out: c=%0d got %0b/%0h want %0b/%0h", c, noc_data_valid_out, noc_data_out, m_out_valid, m_out_data);
      end
      checks++; if (core_rx_valid !== (rx_q.size() > 0)) begin
        errors++;
        $display("FAIL rand_rx_valid: c=%0d got %0b want %0b", c, core_rx_valid, rx_q.size() > 0);
      end
      if (rx_q.size() > 0) begin
        h = rx_q[0];
        checks++; if ({core_rx_payload, core_rx_seq, core_rx_src} !== {h[31:14], h[13:6], h[5:3]}) begin
          errors++;
          $display("FAIL rand_rx_head: c=%0d got %0h/%0h/%0h want %0h/%0h/%0h", c,
                   core_rx_payload, core_rx_seq, core_rx_src, h[31:14], h[13:6], h[5:3]);
        end
      end
      checks++; if ({tx_count, rx_count, drop_count, misroute_count} !== {m_tx_count, m_rx_count, m_drop, m_mis}) begin
        errors++;
        $display("FAIL rand_counters: c=%0d got %0h/%0h/%0h/%0h want %0h/%0h/%0h/%0h", c, tx_count, rx_count,
                 drop_count, misroute_count, m_tx_count, m_rx_count, m_drop, m_mis);
      end
    end
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    test_reset();
    test_inject_basic();
    test_inject_backpressure();
    test_eject_drop();
    test_misroute();
    test_full_pop_push();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
